// File: rtl/mips32_boot_pkg.sv
// Shared types and constants for the MIPS32 boot loader: FSM states, error codes, HLT opcode.
package mips32_boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } boot_state_e;

    localparam logic [1:0] BOOT_OK    = 2'd0;
    localparam logic [1:0] BOOT_OVF   = 2'd1;
    localparam logic [1:0] BOOT_NOHLT = 2'd2;
    localparam logic [1:0] BOOT_WDOG  = 2'd3;

    localparam logic [5:0] OPC_HLT = 6'h3f;

endpackage

// File: rtl/mips32_run_watchdog.sv
// Saturating run-length counter with RUN_LIMIT compare; count updates one cycle after i_en,
// no backpressure. o_timeout is a level decoded from the registered count.
module mips32_run_watchdog #(
    parameter int CNT_W     = 16,
    parameter int RUN_LIMIT = 1024
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_halted,
    output logic [CNT_W-1:0] o_count,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(RUN_LIMIT);

    logic [CNT_W-1:0] r_count;

    // Stops at LIMIT so the count can never wrap back below the watchdog threshold.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !i_halted && (r_count < LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_timeout = (r_count >= LIMIT);

endmodule

// File: rtl/mips32_boot_loader.sv
// Streams a program into instruction memory (1-cycle write latency, 1 word/cycle, in_ready low
// outside LOAD), then releases the core with a one-cycle start pulse and times its run to HLT.
module mips32_boot_loader
    import mips32_boot_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter logic [5:0] HLT_OPC   = OPC_HLT,
    parameter int         RUN_LIMIT = 1024,
    parameter int         CNT_W     = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              core_start,
    input  logic              core_halted,
    output logic [ADDR_W:0]   words_loaded,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              boot_done,
    output logic [1:0]        boot_err
);

    localparam logic [ADDR_W:0] TOP_ADDR = (ADDR_W+1)'((1 << ADDR_W) - 1);

    boot_state_e       r_state;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_core_hold;
    logic              r_core_start;
    logic [ADDR_W:0]   r_words;
    logic              r_boot_done;
    logic [1:0]        r_err;

    logic w_accept;
    logic w_is_hlt;
    logic w_at_top;
    logic w_load_go;
    logic w_start_pend;
    logic w_timeout;

    assign w_accept     = (r_state == LOAD) && r_in_ready && in_valid;
    assign w_is_hlt     = (in_data[31:26] == HLT_OPC);
    assign w_at_top     = (r_words == TOP_ADDR);
    assign w_load_go    = load_req && (r_state inside {IDLE, DONE, ERR});
    // In LOAD with in_ready low, the final HLT word is being written this cycle.
    assign w_start_pend = (r_state == LOAD) && !r_in_ready;

    mips32_run_watchdog #(
        .CNT_W     (CNT_W),
        .RUN_LIMIT (RUN_LIMIT)
    ) u_wdog (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .i_clr     (w_load_go || w_start_pend),
        .i_en      ((r_state == START) || (r_state == RUN)),
        .i_halted  ((r_state == RUN) && core_halted),
        .o_count   (run_cycles),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_core_hold  <= 1'b1;
            r_core_start <= 1'b0;
            r_words      <= '0;
            r_boot_done  <= 1'b0;
            r_err        <= BOOT_OK;
        end else begin
            r_mem_we     <= w_accept;
            r_core_start <= 1'b0;
            if (w_accept) begin
                r_mem_addr  <= r_words[ADDR_W-1:0];
                r_mem_wdata <= in_data;
                r_words     <= r_words + (ADDR_W+1)'(1);
            end
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (load_req) begin
                        r_state     <= LOAD;
                        r_in_ready  <= 1'b1;
                        r_words     <= '0;
                        r_boot_done <= 1'b0;
                        r_err       <= BOOT_OK;
                    end
                end
                LOAD: begin
                    if (w_start_pend) begin
                        r_state      <= START;
                        r_core_start <= 1'b1;
                        r_core_hold  <= 1'b0;
                    end else if (w_accept && in_last) begin
                        r_in_ready <= 1'b0;
                        if (!w_is_hlt) begin
                            r_state <= ERR;
                            r_err   <= BOOT_NOHLT;
                        end
                    end else if (w_accept && w_at_top) begin
                        r_in_ready <= 1'b0;
                        r_state    <= ERR;
                        r_err      <= BOOT_OVF;
                    end
                end
                START: r_state <= RUN;
                RUN: begin
                    if (core_halted) begin
                        r_state     <= DONE;
                        r_boot_done <= 1'b1;
                        r_core_hold <= 1'b1;
                    end else if (w_timeout) begin
                        r_state     <= ERR;
                        r_err       <= BOOT_WDOG;
                        r_core_hold <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign core_hold    = r_core_hold;
    assign core_start   = r_core_start;
    assign words_loaded = r_words;
    assign boot_done    = r_boot_done;
    assign boot_err     = r_err;

endmodule
